pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Central pipeline control for the 5-stage MIPS core. It drives the clear (`*_zero`) and load-enable (`*_stall`) inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards, flushes on control transfers, and sequences a drain-then-halt on a halting syscall. It also keeps stall, flush and cycle statistics.

## Interface
Parameters:
- `PC_BITS`, 32, statistics counter width
- `REG_BITS`, 6, destination/source register index width

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  synchronous reset, active-high (already decided)
- `id_rs`, `id_rt`  in  `REG_BITS` each  source indices of the instruction in ID
- `id_rs_used`, `id_rt_used`  in  1 each  corresponding source is actually read
- `id_jump`  in  1  Jmp/Jal resolved in ID
- `ex_ld`  in  1  instruction in EX is a load (ID/EX `ld_out`)
- `ex_regwrite`  in  1  ID/EX `RegWrite_out`
- `ex_write`  in  `REG_BITS`  ID/EX `write_out`
- `ex_branch_taken`  in  1  taken branch or Jr resolved in EX
- `ex_halt`  in  1  halting Syscall in EX
- `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall`, `mem_wb_stall`  out  1 each  load enable (1 = load)
- `if_id_zero`, `id_ex_zero`, `ex_mem_zero`, `mem_wb_zero`  out  1 each  clear, priority over load
- `halted`  out  1  core halted
- `stall_cnt`, `flush_cnt`, `cycle_cnt`  out  `PC_BITS` each  statistics

## Operation
- States: RUN, DRAIN, HALT. An internal 1-bit drain counter `dcnt` runs in DRAIN.
- `rst`=1 (checked every cycle, including mid-DRAIN or in HALT):
  - All `*_zero` = 1 and all `*_stall` = 0.
  - Next state is RUN, `dcnt` = 0, all counters = 0, `halted` = 0.
- RUN, default: all `*_stall` = 1, all `*_zero` = 0.
- RUN actions are applied with priority, highest first:
  1. `ex_halt`: `pc_stall` = 0, `if_id_stall` = 0, `id_ex_zero` = 1. EX/MEM and MEM/WB load. Next state is DRAIN with `dcnt` = 0.
  2. `ex_branch_taken`: `if_id_zero` = 1, `id_ex_zero` = 1, PC loads the target. `flush_cnt` += 1.
  3. Load-use hazard. Condition: `ex_ld & ex_regwrite & ex_write != 0` and (`id_rs_used & id_rs == ex_write` or `id_rt_used & id_rt == ex_write`). Action: `pc_stall` = 0, `if_id_stall` = 0, `id_ex_zero` = 1 (bubble). `stall_cnt` += 1.
  4. `id_jump`: `if_id_zero` = 1. `flush_cnt` += 1.
- DRAIN: same outputs as the `ex_halt` action in RUN.
  - EX/MEM and MEM/WB advance so older instructions retire.
  - After 2 DRAIN cycles (`dcnt` = 1), next state is HALT.
  - Inputs are ignored in DRAIN.
- HALT: all `*_stall` = 0 and all `*_zero` = 0 (pipeline frozen), `halted` = 1. Only `rst` exits HALT.
- `cycle_cnt` += 1 every non-reset cycle in RUN or DRAIN.
- All counters wrap modulo 2^`PC_BITS`.
- Index 0 never creates a hazard.

## Timing
- All control outputs are combinational from the current state and the same-cycle inputs. Pipeline registers act on them at the next `posedge clk`.
- State, `dcnt`, counters and `halted` are registered. They update at `posedge clk`.
- Load-use costs exactly one bubble. In the next cycle the load is in MEM, `ex_ld` from the bubble is 0, and issue resumes.
- `ex_halt` in cycle N gives DRAIN in cycles N+1 and N+2, and HALT with `halted` = 1 from cycle N+3.
- A simultaneous `ex_branch_taken` and load-use resolves as a branch flush only: `flush_cnt` increments and `stall_cnt` does not.

## Structure
- Package `hazard_pkg` holds:
  - the state enum: RUN=2'b00, DRAIN=2'b01, HALT=2'b10
  - `DRAIN_CYCLES` = 2
  - `REG_ZERO` = 0
- Sub-module `load_use_cmp` is the purely combinational hazard compare, reusable for a future MEM-stage compare.
- The state machine, output decode and counters stay in the top module.

## Test plan
- Reset: hold `rst` 2 cycles → all `*_zero` = 1, all `*_stall` = 0; after release, counters = 0, `halted` = 0, and RUN defaults are driven.
- Load-use: `ex_ld` = 1, `ex_regwrite` = 1, `ex_write` = 8, `id_rs` = 8, `id_rs_used` = 1 → same cycle `pc_stall` = 0, `if_id_stall` = 0, `id_ex_zero` = 1; next cycle `stall_cnt` = 1. Repeat with `ex_write` = 0 → no stall.
- Branch versus load-use in the same cycle → `if_id_zero` = `id_ex_zero` = 1, `pc_stall` = 1; `flush_cnt` = 1, `stall_cnt` = 0.
- `id_jump` alone → only `if_id_zero` = 1; `flush_cnt` increments.
- `ex_halt` at cycle 10 → DRAIN in cycles 11–12 with `ex_mem_stall` = `mem_wb_stall` = 1; `halted` = 1 from cycle 13; `cycle_cnt` then stops.
- `rst` asserted in a DRAIN cycle → next cycle is RUN with `halted` = 0; `PC_BITS` = 4 wrap: 16 stalls give `stall_cnt` = 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/control unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DRAIN = 2'b01,
    HALT  = 2'b10
  } state_t;

  localparam int unsigned DRAIN_CYCLES = 2;
  localparam int unsigned REG_ZERO     = 0;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_cmp.sv
// Combinational load-use compare: a load producing a register read by the
// consumer stage. Stage-agnostic so it can be reused for a MEM-stage compare.
module load_use_cmp
  import hazard_pkg::*;
#(
  parameter int REG_BITS = 6
) (
  input  logic                i_ld,
  input  logic                i_regwrite,
  input  logic [REG_BITS-1:0] i_write,
  input  logic [REG_BITS-1:0] i_rs,
  input  logic                i_rs_used,
  input  logic [REG_BITS-1:0] i_rt,
  input  logic                i_rt_used,
  output logic                o_hazard
);

  logic w_dest_valid;
  logic w_rs_match;
  logic w_rt_match;

  // The zero register is never a real producer, so it can never stall.
  assign w_dest_valid = i_ld & i_regwrite & (i_write != REG_BITS'(REG_ZERO));
  assign w_rs_match   = i_rs_used & (i_rs == i_write);
  assign w_rt_match   = i_rt_used & (i_rt == i_write);
  assign o_hazard     = w_dest_valid & (w_rs_match | w_rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline control: load-use stall, control-transfer flush,
// drain-then-halt sequencing on a halting syscall, plus statistics.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int PC_BITS  = 32,
  parameter int REG_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_rs_used,
  input  logic                id_rt_used,
  input  logic                id_jump,
  input  logic                ex_ld,
  input  logic                ex_regwrite,
  input  logic [REG_BITS-1:0] ex_write,
  input  logic                ex_branch_taken,
  input  logic                ex_halt,
  output logic                pc_stall,
  output logic                if_id_stall,
  output logic                id_ex_stall,
  output logic                ex_mem_stall,
  output logic                mem_wb_stall,
  output logic                if_id_zero,
  output logic                id_ex_zero,
  output logic                ex_mem_zero,
  output logic                mem_wb_zero,
  output logic                halted,
  output logic [PC_BITS-1:0]  stall_cnt,
  output logic [PC_BITS-1:0]  flush_cnt,
  output logic [PC_BITS-1:0]  cycle_cnt
);

  localparam logic [PC_BITS-1:0] CNT_ONE   = {{(PC_BITS-1){1'b0}}, 1'b1};
  localparam logic [PC_BITS-1:0] CNT_CLEAR = {PC_BITS{1'b0}};

  state_t             r_state;
  logic               r_dcnt;
  logic               r_halted;
  logic [PC_BITS-1:0] r_stall_cnt;
  logic [PC_BITS-1:0] r_flush_cnt;
  logic [PC_BITS-1:0] r_cycle_cnt;

  state_t w_next_state;
  logic   w_dcnt_next;
  logic   w_hazard;
  logic   w_stall_inc;
  logic   w_flush_inc;
  logic   w_cycle_inc;

  load_use_cmp #(.REG_BITS(REG_BITS)) u_load_use_cmp (
    .i_ld       (ex_ld),
    .i_regwrite (ex_regwrite),
    .i_write    (ex_write),
    .i_rs       (id_rs),
    .i_rs_used  (id_rs_used),
    .i_rt       (id_rt),
    .i_rt_used  (id_rt_used),
    .o_hazard   (w_hazard)
  );

  // Control decode and next-state; controls are same-cycle from state and inputs.
  always_comb begin
    pc_stall     = 1'b1;
    if_id_stall  = 1'b1;
    id_ex_stall  = 1'b1;
    ex_mem_stall = 1'b1;
    mem_wb_stall = 1'b1;
    if_id_zero   = 1'b0;
    id_ex_zero   = 1'b0;
    ex_mem_zero  = 1'b0;
    mem_wb_zero  = 1'b0;
    w_next_state = r_state;
    w_dcnt_next  = r_dcnt;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;
    w_cycle_inc  = 1'b0;
    if (rst) begin
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      id_ex_stall  = 1'b0;
      ex_mem_stall = 1'b0;
      mem_wb_stall = 1'b0;
      if_id_zero   = 1'b1;
      id_ex_zero   = 1'b1;
      ex_mem_zero  = 1'b1;
      mem_wb_zero  = 1'b1;
      w_next_state = RUN;
      w_dcnt_next  = 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          w_cycle_inc = 1'b1;
          if (ex_halt) begin
            pc_stall     = 1'b0;
            if_id_stall  = 1'b0;
            id_ex_zero   = 1'b1;
            w_next_state = DRAIN;
            w_dcnt_next  = 1'b0;
          end else if (ex_branch_taken) begin
            if_id_zero  = 1'b1;
            id_ex_zero  = 1'b1;
            w_flush_inc = 1'b1;
          end else if (w_hazard) begin
            pc_stall    = 1'b0;
            if_id_stall = 1'b0;
            id_ex_zero  = 1'b1;
            w_stall_inc = 1'b1;
          end else if (id_jump) begin
            if_id_zero  = 1'b1;
            w_flush_inc = 1'b1;
          end else begin
            w_flush_inc = 1'b0;
          end
        end
        DRAIN: begin
          // Front end frozen with a bubble in EX while EX/MEM and MEM/WB retire.
          pc_stall    = 1'b0;
          if_id_stall = 1'b0;
          id_ex_zero  = 1'b1;
          w_cycle_inc = 1'b1;
          if (r_dcnt == 1'(DRAIN_CYCLES - 1)) begin
            w_next_state = HALT;
            w_dcnt_next  = 1'b0;
          end else begin
            w_dcnt_next = r_dcnt + 1'b1;
          end
        end
        HALT: begin
          pc_stall     = 1'b0;
          if_id_stall  = 1'b0;
          id_ex_stall  = 1'b0;
          ex_mem_stall = 1'b0;
          mem_wb_stall = 1'b0;
        end
        default: begin
          pc_stall     = 1'b0;
          if_id_stall  = 1'b0;
          id_ex_stall  = 1'b0;
          ex_mem_stall = 1'b0;
          mem_wb_stall = 1'b0;
          if_id_zero   = 1'b1;
          id_ex_zero   = 1'b1;
          ex_mem_zero  = 1'b1;
          mem_wb_zero  = 1'b1;
          w_next_state = RUN;
          w_dcnt_next  = 1'b0;
        end
      endcase
    end
  end

  // State, drain counter, halted flag and wrapping statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_dcnt      <= 1'b0;
      r_halted    <= 1'b0;
      r_stall_cnt <= CNT_CLEAR;
      r_flush_cnt <= CNT_CLEAR;
      r_cycle_cnt <= CNT_CLEAR;
    end else begin
      r_state  <= w_next_state;
      r_dcnt   <= w_dcnt_next;
      r_halted <= (w_next_state == HALT);
      if (w_stall_inc) r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (w_flush_inc) r_flush_cnt <= r_flush_cnt + CNT_ONE;
      if (w_cycle_inc) r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
    end
  end

  assign halted    = r_halted;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign cycle_cnt = r_cycle_cnt;

endmodule
